// File: rtl/pc_gen_pkg.sv
// Shared fetch-side types and constants: FSM encoding, default boot address, instruction size.
// Also holds the small address helpers that the PC generator and its users share.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES          = 32'd4;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [31:0] addr);
    return |addr[1:0];
  endfunction

endpackage

// File: rtl/pc_gen.sv
// PC generator feeding instruction fetch; 1-cycle fetch latency, redirect/trap visible next cycle.
// Stall holds pc, pc_fetched and fetch_valid; trap and redirect override stall.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        trap_valid,
  input  logic [31:0] trap_vector,
  input  logic        halt_req,
  output logic [31:0] pc,
  output logic [31:0] pc_fetched,
  output logic        fetch_valid,
  output logic        misaligned,
  output logic [31:0] bad_addr,
  output logic        halted,
  output logic [31:0] fetch_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc_fetched_q, pc_fetched_d;
  logic         fetch_valid_q, fetch_valid_d;
  logic         misaligned_q, misaligned_d;
  logic [31:0]  bad_addr_q, bad_addr_d;
  logic         halted_q, halted_d;
  logic [31:0]  fetch_count_q, fetch_count_d;

  logic         advance;
  logic         take_target;
  logic [31:0]  target_addr;

  // Decide what happens this cycle; the register updates are applied below.
  always_comb begin
    state_d     = state_q;
    advance     = 1'b0;
    take_target = 1'b0;
    target_addr = 32'h0;

    unique case (state_q)
      BOOT: begin
        state_d = RUN;
        advance = !stall;
      end
      RUN: begin
        if (trap_valid) begin
          take_target = 1'b1;
          target_addr = trap_vector;
        end else if (redirect_valid) begin
          take_target = 1'b1;
          target_addr = redirect_target;
        end else if (halt_req) begin
          state_d = HALT;
        end else if (!stall) begin
          advance = 1'b1;
        end
      end
      HALT: begin
        if (trap_valid) begin
          state_d     = RUN;
          take_target = 1'b1;
          target_addr = trap_vector;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    pc_d          = pc_q;
    pc_fetched_d  = pc_fetched_q;
    fetch_valid_d = fetch_valid_q;
    misaligned_d  = 1'b0;
    bad_addr_d    = bad_addr_q;
    fetch_count_d = fetch_count_q;
    halted_d      = (state_d == HALT);

    if (take_target) begin
      // The fetch of the old pc is already in flight; kill it rather than let it reach decode.
      pc_d          = align_word(target_addr);
      fetch_valid_d = 1'b0;
      misaligned_d  = is_misaligned(target_addr);
      if (is_misaligned(target_addr)) begin
        bad_addr_d = target_addr;
      end
    end else if (advance) begin
      pc_fetched_d  = pc_q;
      fetch_valid_d = 1'b1;
      pc_d          = pc_q + INSTR_BYTES;
      fetch_count_d = fetch_count_q + 32'd1;
    end else if (state_q != RUN || state_d != RUN) begin
      // Boot under stall, halt entry and halted cycles present nothing; a RUN stall keeps its output.
      fetch_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      pc_fetched_q  <= 32'h0;
      fetch_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      bad_addr_q    <= 32'h0;
      halted_q      <= 1'b0;
      fetch_count_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_fetched_q  <= pc_fetched_d;
      fetch_valid_q <= fetch_valid_d;
      misaligned_q  <= misaligned_d;
      bad_addr_q    <= bad_addr_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign pc          = pc_q;
  assign pc_fetched  = pc_fetched_q;
  assign fetch_valid = fetch_valid_q;
  assign misaligned  = misaligned_q;
  assign bad_addr    = bad_addr_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: each step drives inputs, queues the expected registered outputs,
// and compares them one clock later.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_valid;
  logic [31:0] trap_vector;
  logic        halt_req;
  logic [31:0] pc;
  logic [31:0] pc_fetched;
  logic        fetch_valid;
  logic        misaligned;
  logic [31:0] bad_addr;
  logic        halted;
  logic [31:0] fetch_count;

  always #5 clk = ~clk;

  pc_gen #(.RESET_VECTOR(32'h0000_0100)) dut (
    .clk             (clk),
    .arst_n          (arst_n),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_valid      (trap_valid),
    .trap_vector     (trap_vector),
    .halt_req        (halt_req),
    .pc              (pc),
    .pc_fetched      (pc_fetched),
    .fetch_valid     (fetch_valid),
    .misaligned      (misaligned),
    .bad_addr        (bad_addr),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pcf;
    bit          chk_pcf;
    bit          fv;
    bit          mis;
    logic [31:0] bad;
    bit          hlt;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_no  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_pc"},  pc, 32'h0000_0100);
    check_eq({tag, "_pcf"}, pc_fetched, 32'h0);
    check_eq({tag, "_fv"},  32'(fetch_valid), 32'h0);
    check_eq({tag, "_mis"}, 32'(misaligned), 32'h0);
    check_eq({tag, "_bad"}, bad_addr, 32'h0);
    check_eq({tag, "_hlt"}, 32'(halted), 32'h0);
    check_eq({tag, "_cnt"}, fetch_count, 32'h0);
  endtask

  // Drive one cycle of stimulus, queue what the outputs must be after the edge, then compare.
  task automatic step(input bit st, input bit rv, input logic [31:0] rt,
                      input bit tv, input logic [31:0] tt, input bit hr,
                      input logic [31:0] e_pc, input logic [31:0] e_pcf, input bit e_chk_pcf,
                      input bit e_fv, input bit e_mis, input logic [31:0] e_bad,
                      input bit e_hlt, input logic [31:0] e_cnt);
    exp_t  e;
    string tag;
    stall           = st;
    redirect_valid  = rv;
    redirect_target = rt;
    trap_valid      = tv;
    trap_vector     = tt;
    halt_req        = hr;
    e.pc = e_pc; e.pcf = e_pcf; e.chk_pcf = e_chk_pcf; e.fv = e_fv;
    e.mis = e_mis; e.bad = e_bad; e.hlt = e_hlt; e.cnt = e_cnt;
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    step_no++;
    tag = $sformatf("s%0d", step_no);
    check_eq({tag, "_sb"}, 32'(sb_q.size() != 0), 32'h1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_eq({tag, "_pc"},  pc, e.pc);
      check_eq({tag, "_fv"},  32'(fetch_valid), 32'(e.fv));
      check_eq({tag, "_mis"}, 32'(misaligned), 32'(e.mis));
      check_eq({tag, "_hlt"}, 32'(halted), 32'(e.hlt));
      check_eq({tag, "_cnt"}, fetch_count, e.cnt);
      if (e.chk_pcf) check_eq({tag, "_pcf"}, pc_fetched, e.pcf);
      if (e.mis)     check_eq({tag, "_bad"}, bad_addr, e.bad);
    end
  endtask

  initial begin
    arst_n          = 1'b0;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    trap_valid      = 1'b0;
    trap_vector     = 32'h0;
    halt_req        = 1'b0;

    #12;
    check_reset_state("rst");
    @(negedge clk);
    arst_n = 1'b1;

    //   st rv rt            tv tt            hr  pc            pcf           cp fv mis bad           hlt cnt
    step(0, 0, 32'h0,        0, 32'h0,        0,  32'h104,      32'h100,      1, 1, 0,  32'h0,        0,  32'd1);
    step(0, 0, 32'h0,        0, 32'h0,        0,  32'h108,      32'h104,      1, 1, 0,  32'h0,        0,  32'd2);
    for (int i = 0; i < 3; i++)
      step(1, 0, 32'h0,      0, 32'h0,        0,  32'h108,      32'h104,      1, 1, 0,  32'h0,        0,  32'd2);
    step(0, 0, 32'h0,        0, 32'h0,        0,  32'h10C,      32'h108,      1, 1, 0,  32'h0,        0,  32'd3);
    step(0, 1, 32'h200,      0, 32'h0,        0,  32'h200,      32'h0,        0, 0, 0,  32'h0,        0,  32'd3);
    step(0, 0, 32'h0,        0, 32'h0,        0,  32'h204,      32'h200,      1, 1, 0,  32'h0,        0,  32'd4);
    step(1, 1, 32'h300,      1, 32'h80,       0,  32'h80,       32'h0,        0, 0, 0,  32'h0,        0,  32'd4);
    step(0, 0, 32'h0,        0, 32'h0,        0,  32'h84,       32'h80,       1, 1, 0,  32'h0,        0,  32'd5);
    step(0, 1, 32'h202,      0, 32'h0,        0,  32'h200,      32'h0,        0, 0, 1,  32'h202,      0,  32'd5);
    step(0, 0, 32'h0,        0, 32'h0,        0,  32'h204,      32'h200,      1, 1, 0,  32'h0,        0,  32'd6);
    step(0, 0, 32'h0,        0, 32'h0,        1,  32'h204,      32'h0,        0, 0, 0,  32'h0,        1,  32'd6);
    step(1, 1, 32'h300,      0, 32'h0,        1,  32'h204,      32'h0,        0, 0, 0,  32'h0,        1,  32'd6);
    step(0, 0, 32'h0,        0, 32'h0,        0,  32'h204,      32'h0,        0, 0, 0,  32'h0,        1,  32'd6);
    step(0, 0, 32'h0,        1, 32'h40,       0,  32'h40,       32'h0,        0, 0, 0,  32'h0,        0,  32'd6);
    step(0, 0, 32'h0,        0, 32'h0,        0,  32'h44,       32'h40,       1, 1, 0,  32'h0,        0,  32'd7);
    step(0, 1, 32'hFFFF_FFFC, 0, 32'h0,       0,  32'hFFFF_FFFC, 32'h0,       0, 0, 0,  32'h0,        0,  32'd7);
    step(0, 0, 32'h0,        0, 32'h0,        0,  32'h0,        32'hFFFF_FFFC, 1, 1, 0, 32'h0,        0,  32'd8);
    step(0, 0, 32'h0,        0, 32'h0,        0,  32'h4,        32'h0,        1, 1, 0,  32'h0,        0,  32'd9);
    step(0, 1, 32'h100,      0, 32'h0,        1,  32'h100,      32'h0,        0, 0, 0,  32'h0,        0,  32'd9);
    step(0, 0, 32'h0,        1, 32'h43,       0,  32'h40,       32'h0,        0, 0, 1,  32'h43,       0,  32'd9);
    step(0, 0, 32'h0,        0, 32'h0,        0,  32'h44,       32'h40,       1, 1, 0,  32'h0,        0,  32'd10);

    // Reset in the middle of operation, then boot again with a stall held through BOOT.
    arst_n = 1'b0;
    #1;
    check_reset_state("mid_rst");
    @(negedge clk);
    arst_n = 1'b1;
    step(1, 0, 32'h0,        0, 32'h0,        0,  32'h100,      32'h0,        1, 0, 0,  32'h0,        0,  32'd0);
    step(0, 0, 32'h0,        0, 32'h0,        0,  32'h104,      32'h100,      1, 1, 0,  32'h0,        0,  32'd1);
    step(0, 0, 32'h0,        0, 32'h0,        0,  32'h108,      32'h104,      1, 1, 0,  32'h0,        0,  32'd2);

    check_eq("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
